// File: rtl/regfile_wb_arb_pkg.sv
// Shared register-file definitions for the writeback arbiter.
// Also holds the default pending-FIFO depth and starvation threshold.
package regfile_wb_arb_pkg;
    localparam int                RegAddrBus  = 5;
    localparam int                RegBus      = 32;
    localparam logic              WriteEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord    = '0;
    localparam int                WbPendDepth = 2;
    localparam int                WbAgeMax    = 3;
endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-write FIFO for long-latency results.
// Each entry carries a kill bit, and address-match lookups ignore killed entries.
module wb_pend_fifo
    import regfile_wb_arb_pkg::*;
#(
    parameter int DEPTH = WbPendDepth
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [RegAddrBus-1:0]       push_addr,
    input  logic [RegBus-1:0]           push_data,
    input  logic                        pop,
    input  logic                        kill_en,
    input  logic [RegAddrBus-1:0]       kill_addr,
    input  logic [RegAddrBus-1:0]       chk_addr1,
    input  logic [RegAddrBus-1:0]       chk_addr2,
    output logic [RegAddrBus-1:0]       head_addr,
    output logic [RegBus-1:0]           head_data,
    output logic                        head_kill,
    output logic [$clog2(DEPTH+1)-1:0]  cnt,
    output logic                        hit1,
    output logic                        hit2
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [RegAddrBus-1:0] mem_addr [DEPTH];
    logic [RegBus-1:0]     mem_data [DEPTH];
    logic [DEPTH-1:0]      live;
    logic [DEPTH-1:0]      kill;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Push never lands on a live slot and pop never targets the push slot,
    // so kill, pop and push updates touch disjoint state within one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            live   <= '0;
            kill   <= '0;
        end else begin
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (live[i] && mem_addr[i] == kill_addr) kill[i] <= 1'b1;
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= ptr_next(rd_ptr);
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                kill[wr_ptr] <= 1'b0;
                wr_ptr       <= ptr_next(wr_ptr);
            end
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign head_kill = kill[rd_ptr];

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && !kill[i] && chk_addr1 != '0 && mem_addr[i] == chk_addr1) hit1 = 1'b1;
            if (live[i] && !kill[i] && chk_addr2 != '0 && mem_addr[i] == chk_addr2) hit2 = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file write-port arbiter: the pipeline writeback has absolute priority,
// and long-latency results are bypassed or parked in a pending FIFO with starvation aging.
module regfile_wb_arb
    import regfile_wb_arb_pkg::*;
#(
    parameter int PEND_DEPTH = WbPendDepth,
    parameter int AGE_MAX    = WbAgeMax
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_we,
    input  logic [RegAddrBus-1:0] p_waddr,
    input  logic [RegBus-1:0]     p_wdata,
    input  logic                  l_valid,
    input  logic [RegAddrBus-1:0] l_waddr,
    input  logic [RegBus-1:0]     l_wdata,
    output logic                  l_ready,
    output logic                  wb_we,
    output logic [RegAddrBus-1:0] wb_waddr,
    output logic [RegBus-1:0]     wb_wdata,
    input  logic [RegAddrBus-1:0] chk_raddr1,
    input  logic [RegAddrBus-1:0] chk_raddr2,
    output logic                  chk_hit1,
    output logic                  chk_hit2,
    output logic                  stall_req,
    output logic [1:0]            pend_cnt
);
    localparam int CW = $clog2(PEND_DEPTH + 1);

    logic [CW-1:0]         cnt;
    logic [1:0]            age;
    logic [RegAddrBus-1:0] head_addr;
    logic [RegBus-1:0]     head_data;
    logic                  head_kill;
    logic                  head_live;
    logic                  p_sel;
    logic                  pop;
    logic                  bypass;
    logic                  push;

    assign head_live = (cnt != '0);
    assign p_sel     = rst && p_we && (p_waddr != '0);
    assign l_ready   = rst && (cnt < CW'(PEND_DEPTH));
    assign pend_cnt  = 2'(cnt);
    assign stall_req = (age == 2'(AGE_MAX));

    // A killed head still consumes the port for its pop cycle, blocking bypass.
    always_comb begin
        wb_we    = 1'b0;
        wb_waddr = '0;
        wb_wdata = ZeroWord;
        pop      = 1'b0;
        bypass   = 1'b0;
        if (p_sel) begin
            wb_we    = WriteEnable;
            wb_waddr = p_waddr;
            wb_wdata = p_wdata;
        end else if (head_live) begin
            pop = 1'b1;
            if (!head_kill) begin
                wb_we    = WriteEnable;
                wb_waddr = head_addr;
                wb_wdata = head_data;
            end
        end else if (rst && l_valid && l_waddr != '0) begin
            bypass   = 1'b1;
            wb_we    = WriteEnable;
            wb_waddr = l_waddr;
            wb_wdata = l_wdata;
        end
    end

    // Accepted requests that are bypassed, target $0 or are overwritten by a
    // same-cycle pipeline write are dropped rather than queued.
    assign push = l_valid && l_ready && !bypass && (l_waddr != '0)
                  && !(p_sel && p_waddr == l_waddr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (pop || !head_live) begin
            age <= '0;
        end else if (p_sel && age != 2'(AGE_MAX)) begin
            age <= age + 2'd1;
        end
    end

    wb_pend_fifo #(
        .DEPTH(PEND_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (l_waddr),
        .push_data (l_wdata),
        .pop       (pop),
        .kill_en   (p_sel),
        .kill_addr (p_waddr),
        .chk_addr1 (chk_raddr1),
        .chk_addr2 (chk_raddr2),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_kill (head_kill),
        .cnt       (cnt),
        .hit1      (chk_hit1),
        .hit2      (chk_hit2)
    );
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: a queue-based model checked every cycle,
// plus literal expectations for bypass, contention, WAW kill, $0 and mid-cycle reset.
module tb_regfile_wb_arb;
    localparam int DEPTH   = 2;
    localparam int AGE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_we = 1'b0;
    logic [4:0]  p_waddr = '0;
    logic [31:0] p_wdata = '0;
    logic        l_valid = 1'b0;
    logic [4:0]  l_waddr = '0;
    logic [31:0] l_wdata = '0;
    logic        l_ready;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [4:0]  chk_raddr1 = '0;
    logic [4:0]  chk_raddr2 = '0;
    logic        chk_hit1;
    logic        chk_hit2;
    logic        stall_req;
    logic [1:0]  pend_cnt;

    int total = 0;
    int bad   = 0;

    regfile_wb_arb #(.PEND_DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .l_valid(l_valid), .l_waddr(l_waddr), .l_wdata(l_wdata), .l_ready(l_ready),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2),
        .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .stall_req(stall_req), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Regfile image built only from what the DUT actually writes.
    logic [31:0] dut_rf [32];
    initial for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    always @(posedge clk) if (wb_we) dut_rf[wb_waddr] <= wb_wdata;

    // Behavioural model: pending writes as a queue, age as a plain integer.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          k;
    } ent_t;
    ent_t q[$];
    int   m_age = 0;

    function automatic bit model_hit(input logic [4:0] ra);
        bit h = 1'b0;
        if (ra != 0) foreach (q[i]) if (q[i].a == ra && !q[i].k) h = 1'b1;
        return h;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_age = 0;
        end else begin
            int sz;
            bit ps, popd, byp, acc;
            sz   = q.size();
            ps   = p_we && p_waddr != 0;
            popd = !ps && sz > 0;
            byp  = !ps && sz == 0 && l_valid && l_waddr != 0;
            acc  = l_valid && sz < DEPTH;
            if (sz == 0 || popd) m_age = 0;
            else if (ps && m_age < AGE_MAX) m_age++;
            if (ps) foreach (q[i]) if (q[i].a == p_waddr) q[i].k = 1'b1;
            if (popd) void'(q.pop_front());
            if (acc && !byp && l_waddr != 0 && !(ps && p_waddr == l_waddr))
                q.push_back('{l_waddr, l_wdata, 1'b0});
        end
    end

    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;

    always @(negedge clk) begin
        e_we = 1'b0; e_a = '0; e_d = '0;
        if (rst) begin
            if (p_we && p_waddr != 0) begin
                e_we = 1'b1; e_a = p_waddr; e_d = p_wdata;
            end else if (q.size() > 0) begin
                if (!q[0].k) begin e_we = 1'b1; e_a = q[0].a; e_d = q[0].d; end
            end else if (l_valid && l_waddr != 0) begin
                e_we = 1'b1; e_a = l_waddr; e_d = l_wdata;
            end
        end
        chk("m_wb_we",    wb_we,    e_we);
        chk("m_wb_waddr", wb_waddr, e_a);
        chk("m_wb_wdata", wb_wdata, e_d);
        chk("m_l_ready",  l_ready,  rst && q.size() < DEPTH);
        chk("m_hit1",     chk_hit1, rst && model_hit(chk_raddr1));
        chk("m_hit2",     chk_hit2, rst && model_hit(chk_raddr2));
        chk("m_stall",    stall_req, m_age == AGE_MAX);
        chk("m_pend",     pend_cnt, q.size());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_l_ready", l_ready, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_stall", stall_req, 0);
        rst = 1'b1;
        #1;
        chk("rel_l_ready", l_ready, 1);

        // Bypass with empty FIFO
        tick(); l_valid = 1; l_waddr = 5; l_wdata = 32'hA5A5A5A5; #1;
        chk("byp_we", wb_we, 1);
        chk("byp_addr", wb_waddr, 5);
        chk("byp_data", wb_wdata, 32'hA5A5A5A5);
        tick(); l_valid = 0; #1;
        chk("byp_pend", pend_cnt, 0);
        chk("byp_rf5", dut_rf[5], 32'hA5A5A5A5);

        // Contention: pipeline owns the port, l writes 7 then 8
        tick(); p_we = 1; p_waddr = 3; p_wdata = 32'h33;
        l_valid = 1; l_waddr = 7; l_wdata = 32'h77; #1;
        chk("ct_wb_addr", wb_waddr, 3);
        chk("ct_l_ready0", l_ready, 1);
        tick(); l_waddr = 8; l_wdata = 32'h88; #1;
        chk("ct_pend1", pend_cnt, 1);
        tick(); l_valid = 0; chk_raddr1 = 7; chk_raddr2 = 8; #1;
        chk("ct_pend2", pend_cnt, 2);
        chk("ct_l_ready", l_ready, 0);
        chk("ct_hit7", chk_hit1, 1);
        chk("ct_hit8", chk_hit2, 1);
        chk("ct_stall_a1", stall_req, 0);
        tick(); #1;
        chk("ct_stall_a2", stall_req, 0);
        tick(); #1;
        chk("ct_stall_a3", stall_req, 1);
        chk("ct_prio_addr", wb_waddr, 3);
        tick(); #1;
        chk("ct_stall_sat", stall_req, 1);
        p_we = 0; #1;
        chk("ct_drain7_we", wb_we, 1);
        chk("ct_drain7_addr", wb_waddr, 7);
        chk("ct_drain7_data", wb_wdata, 32'h77);
        tick(); #1;
        chk("ct_drain8_addr", wb_waddr, 8);
        chk("ct_drain8_data", wb_wdata, 32'h88);
        chk("ct_age_clr", stall_req, 0);
        tick(); #1;
        chk("ct_idle_we", wb_we, 0);
        chk("ct_idle_pend", pend_cnt, 0);
        chk("ct_rf7", dut_rf[7], 32'h77);
        chk("ct_rf8", dut_rf[8], 32'h88);

        // WAW kill on addr 9
        p_we = 1; p_waddr = 3; p_wdata = 32'h33; l_valid = 1; l_waddr = 9; l_wdata = 32'h99;
        tick(); l_valid = 0; p_waddr = 9; p_wdata = 32'h11; chk_raddr1 = 9; #1;
        chk("waw_hit_pre", chk_hit1, 1);
        chk("waw_p_data", wb_wdata, 32'h11);
        tick(); p_we = 0; #1;
        chk("waw_hit_killed", chk_hit1, 0);
        chk("waw_no_write", wb_we, 0);
        chk("waw_pend1", pend_cnt, 1);
        tick(); #1;
        chk("waw_pend0", pend_cnt, 0);
        chk("waw_rf9", dut_rf[9], 32'h11);

        // Zero register handling
        l_valid = 1; l_waddr = 0; l_wdata = 32'hDEAD; #1;
        chk("z_l_ready", l_ready, 1);
        chk("z_l_we", wb_we, 0);
        tick(); l_valid = 0; #1;
        chk("z_l_pend", pend_cnt, 0);
        p_we = 1; p_waddr = 3; p_wdata = 32'h33; l_valid = 1; l_waddr = 12; l_wdata = 32'hC;
        tick(); l_valid = 0; p_waddr = 0; #1;
        chk("z_p_pend", pend_cnt, 1);
        chk("z_p_we", wb_we, 1);
        chk("z_p_addr", wb_waddr, 12);
        chk("z_p_data", wb_wdata, 32'hC);
        tick(); p_we = 0; #1;
        chk("z_p_pend0", pend_cnt, 0);

        // Reset mid-operation with a full FIFO and stall asserted
        p_we = 1; p_waddr = 3; l_valid = 1; l_waddr = 20; l_wdata = 32'h1;
        chk_raddr1 = 20; chk_raddr2 = 21;
        tick(); l_waddr = 21; l_wdata = 32'h2;
        tick(); l_valid = 0;
        tick();
        tick(); l_valid = 1; l_waddr = 22; #1;
        chk("rm_stall", stall_req, 1);
        chk("rm_pend", pend_cnt, 2);
        #1; rst = 0; #1;
        chk("rm_wb_we", wb_we, 0);
        chk("rm_wb_waddr", wb_waddr, 0);
        chk("rm_wb_wdata", wb_wdata, 0);
        chk("rm_l_ready", l_ready, 0);
        chk("rm_hit1", chk_hit1, 0);
        chk("rm_hit2", chk_hit2, 0);
        chk("rm_stall0", stall_req, 0);
        chk("rm_pend0", pend_cnt, 0);
        tick(); rst = 1; p_we = 0; l_valid = 0; #1;
        chk("rm_rel_l_ready", l_ready, 1);
        chk("rm_rel_pend", pend_cnt, 0);
        chk("rm_rel_hit1", chk_hit1, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL provide parameter PEND_DEPTH, default 2: pending-write FIFO entries.
REQ-002 SHALL provide parameter AGE_MAX, default 3: starvation threshold in cycles.
REQ-003 SHALL provide port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL provide port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL provide ports p_we/p_waddr/p_wdata, input, 1/5/32: pipeline writeback; no backpressure; highest priority.
REQ-006 SHALL provide ports l_valid/l_waddr/l_wdata, input, 1/5/32: long-latency unit (div/load) write request.
REQ-007 SHALL provide port l_ready, output, 1: transfer occurs on l_valid&&l_ready at clock edge.
REQ-008 SHALL provide ports wb_we/wb_waddr/wb_wdata, output, 1/5/32: to regfile write port.
REQ-009 SHALL provide ports chk_raddr1/chk_raddr2, input, 5, and chk_hit1/chk_hit2, output, 1: decode hazard lookup.
REQ-010 SHALL provide port stall_req, output, 1: asks pipeline to leave the port idle next cycle.
REQ-011 SHALL provide port pend_cnt, output, 2: live FIFO entries.

Function
REQ-012 SHALL select the port each cycle, combinationally and with zero latency: (1) pipeline if p_we and p_waddr!=0; else (2) FIFO head; else (3) bypass l request if l_valid and l_waddr!=0; else wb_we=0.
REQ-013 SHALL drive wb_waddr/wb_wdata to zero whenever wb_we=0.
REQ-014 SHALL assert l_ready iff pend_cnt<PEND_DEPTH and reset is released.
REQ-015 SHALL enqueue an accepted l request unless it was bypassed, its address is 0, or a same-cycle pipeline write targets the same address; every dropped request still counts as accepted.
REQ-016 SHALL, on a pipeline write, set the kill bit of every FIFO entry with matching address (pipeline write is younger).
REQ-017 SHALL pop a killed head without asserting wb_we; in that cycle neither bypass nor a second pop is allowed.
REQ-018 SHALL handle simultaneous pop and push in one cycle, keeping pend_cnt unchanged; pointers wrap modulo PEND_DEPTH.
REQ-019 SHALL assert chk_hitN iff chk_raddrN!=0 and matches a live, unkilled FIFO entry.
REQ-020 SHALL keep a 2-bit age counter: +1 (saturating at AGE_MAX) per cycle with FIFO non-empty and the port taken by the pipeline; cleared on any pop or when FIFO is empty.
REQ-021 SHALL drive stall_req = (age==AGE_MAX), registered-state-derived only.
REQ-022 SHALL keep absolute pipeline priority even while stall_req=1; age stays saturated.

Reset
REQ-023 SHALL, while rst=0, clear FIFO, pointers, kill bits and age asynchronously, and drive l_ready=0, wb_we=0, wb_waddr=0, wb_wdata=0, chk_hit1/2=0, stall_req=0, pend_cnt=0.
REQ-024 SHALL discard in-flight l requests when reset asserts mid-operation; l_ready rises the first cycle after release.

Structure
REQ-025 SHALL take RegAddrBus, RegBus, WriteEnable and ZeroWord from the shared defines header; WbPendDepth and WbAgeMax SHALL be added there.
REQ-026 SHALL instantiate one sub-module, wb_pend_fifo: storage, kill bits, address-match outputs.
REQ-027 SHALL contain arbitration, age and reset logic in the top module only.

Verification
REQ-028 Bypass: FIFO empty, p_we=0, l_valid with addr 5, data 0xA5A5A5A5 -> same cycle wb_we=1, addr 5, data 0xA5A5A5A5; pend_cnt stays 0.
REQ-029 Contention: p_we addr 3 every cycle; l writes addr 7 and addr 8 -> pend_cnt=2, l_ready=0, chk_hit for 7 and 8; stall_req after 3 cycles; p_we drops -> addr 7 written, then addr 8.
REQ-030 WAW kill: FIFO holds addr 9; pipeline writes addr 9, data 0x11 -> entry killed, chk_hit for 9 = 0; next free cycle no write; regfile $9 = 0x11.
REQ-031 Zero register: l write addr 0 accepted -> never enqueued; p_we addr 0 -> port free for FIFO head that cycle.
REQ-032 Reset mid-operation: FIFO=2, stall_req=1, rst pulled low between edges -> all outputs zero immediately; after release l_ready=1, pend_cnt=0.
